// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle core: opcodes, functs,
// FSM states and the 4-bit ALU control code of the single-cycle core.
package riscv_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_BAD = 4'b1111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
        S_MEMWR, S_EXEC, S_ALUWB, S_ADDIEX, S_ADDIWB,
        S_BRANCH, S_JUMP, S_HALT
    } state_t;

    function automatic logic [3:0] funct_to_alu(input logic [5:0] funct);
        case (funct)
            FN_ADD:  return ALU_ADD;
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_BAD;
        endcase
    endfunction

    function automatic logic [31:0] alu(input logic [3:0] ctl,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
        case (ctl)
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_SLT: return {31'd0, $signed(a) < $signed(b)};
            default: return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// Register file: NREGS x 32, two asynchronous read ports,
// one synchronous write port, register 0 hardwired to zero.
module mc_regfile #(
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    input  logic [AW-1:0] wa,
    input  logic [31:0]   wd,
    output logic [31:0]   rd1,
    output logic [31:0]   rd2
);

    logic [31:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (we && wa != '0) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == '0) ? 32'd0 : regs[ra1];
    assign rd2 = (ra2 == '0) ? 32'd0 : regs[ra2];

endmodule

// File: rtl/riscv_mc_core.sv
// Multicycle MIPS-subset core on one unified req/ready memory port.
// Define RISCV_MC_PERF_EN to add cycle_cnt/instret_cnt counter ports.
module riscv_mc_core
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NREGS    = 32,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic              halted,
    output logic [31:0]       pc
`ifdef RISCV_MC_PERF_EN
    ,
    output logic [31:0]       cycle_cnt,
    output logic [31:0]       instret_cnt
`endif
);

    localparam int RW = $clog2(NREGS);

    state_t      state, state_n;
    logic [31:0] pc_q, ir, mdr, alu_out, a_q, b_q;
    logic [31:0] rd1, rd2, simm, alu_y, addr_full;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [3:0]  alu_ctl;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    assign op      = ir[31:26];
    assign rs      = ir[25:21];
    assign rt      = ir[20:16];
    assign rd      = ir[15:11];
    assign simm    = {{16{ir[15]}}, ir[15:0]};
    assign alu_ctl = funct_to_alu(ir[5:0]);
    assign alu_y   = alu(alu_ctl, a_q, b_q);

    mc_regfile #(.NREGS(NREGS), .AW(RW)) u_rf (
        .clk (clk),
        .we  (rf_we),
        .ra1 (rs[RW-1:0]),
        .ra2 (rt[RW-1:0]),
        .wa  (rf_wa[RW-1:0]),
        .wd  (rf_wd),
        .rd1 (rd1),
        .rd2 (rd2)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_FETCH:  if (mem_ready) state_n = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_n = S_MEMADR;
                    OP_RTYPE:     state_n = S_EXEC;
                    OP_ADDI:      state_n = S_ADDIEX;
                    OP_BEQ:       state_n = S_BRANCH;
                    OP_J:         state_n = S_JUMP;
                    default:      state_n = S_HALT;
                endcase
            end
            S_MEMADR: state_n = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_n = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_n = S_FETCH;
            S_EXEC:   state_n = (alu_ctl == ALU_BAD) ? S_HALT : S_ALUWB;
            S_ADDIEX: state_n = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB,
            S_BRANCH, S_JUMP: state_n = S_FETCH;
            S_HALT:   state_n = S_HALT;
            default:  state_n = S_HALT;
        endcase
    end

    // Memory outputs are Moore; reset masks the request immediately.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_full = alu_out;
        unique case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                addr_full = pc_q;
            end
            S_MEMRD: mem_req = 1'b1;
            S_MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
        end
    end

    assign mem_addr  = {addr_full[ADDR_W-1:2], 2'b00};
    assign mem_wdata = b_q;
    assign halted    = (state == S_HALT);
    assign pc        = pc_q;

    always_comb begin
        rf_we = 1'b0;
        rf_wa = rt;
        rf_wd = alu_out;
        unique case (state)
            S_MEMWB: begin
                rf_we = 1'b1;
                rf_wd = mdr;
            end
            S_ALUWB: begin
                rf_we = 1'b1;
                rf_wa = rd;
            end
            S_ADDIWB: rf_we = 1'b1;
            default: ;
        endcase
        if (reset) rf_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            ir      <= 32'd0;
            mdr     <= 32'd0;
            alu_out <= 32'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
        end else begin
            unique case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir   <= mem_rdata;
                        pc_q <= pc_q + 32'd4;
                    end
                end
                S_DECODE: begin
                    a_q     <= rd1;
                    b_q     <= rd2;
                    alu_out <= pc_q + (simm << 2);
                end
                S_MEMADR, S_ADDIEX: alu_out <= a_q + simm;
                S_MEMRD:  if (mem_ready) mdr <= mem_rdata;
                S_EXEC:   if (alu_ctl != ALU_BAD) alu_out <= alu_y;
                S_BRANCH: if (a_q == b_q) pc_q <= alu_out;
                S_JUMP:   pc_q <= {pc_q[31:28], ir[25:0], 2'b00};
                default: ;
            endcase
        end
    end

`ifdef RISCV_MC_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt   <= 32'd0;
            instret_cnt <= 32'd0;
        end else if (state != S_HALT) begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (state != S_FETCH && state_n == S_FETCH) begin
                instret_cnt <= instret_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_riscv_mc_core.sv
// Directed testbench for riscv_mc_core with a unified memory model
// that can insert wait states on data accesses below 0x100.
module tb_riscv_mc_core;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req, mem_we, mem_ready, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
`ifdef RISCV_MC_PERF_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    logic [31:0] mem [256];
    int          data_wait;
    int          wcnt = 0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          stable_err, wait_cycles;
    logic        prev_wait = 1'b0;
    logic        prev_we;
    logic [31:0] prev_addr, prev_wd;

    int          q_cyc [$];
    logic [31:0] q_addr [$];
    logic [31:0] q_wd [$];
    logic        q_we [$];
`ifdef RISCV_MC_PERF_EN
    logic [31:0] q_cc [$];
    logic [31:0] q_ir [$];
`endif

    riscv_mc_core #(.RESET_PC(32'h100)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .halted    (halted),
        .pc        (pc)
`ifdef RISCV_MC_PERF_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
`endif
    );

    always #5 clk = ~clk;

    assign mem_ready = mem_req && ((mem_addr >= 32'h100) || (wcnt >= data_wait));
    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (!reset) begin
            if (prev_wait && (mem_req !== 1'b1 || mem_addr !== prev_addr ||
                              mem_we !== prev_we || mem_wdata !== prev_wd))
                stable_err++;
            if (mem_req && !mem_ready) wait_cycles++;
            if (mem_req && mem_ready) begin
                q_cyc.push_back(cyc);
                q_addr.push_back(mem_addr);
                q_wd.push_back(mem_wdata);
                q_we.push_back(mem_we);
`ifdef RISCV_MC_PERF_EN
                q_cc.push_back(cycle_cnt);
                q_ir.push_back(instret_cnt);
`endif
                if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
            end
        end
        prev_wait = !reset && mem_req && !mem_ready;
        prev_addr = mem_addr;
        prev_we   = mem_we;
        prev_wd   = mem_wdata;
        wcnt <= (mem_req && !mem_ready) ? wcnt + 1 : 0;
        cyc++;
    end

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] target);
        return {6'h02, target[27:2]};
    endfunction

    task automatic hold_reset();
        @(negedge clk);
        reset = 1'b1;
        data_wait = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        q_cyc.delete(); q_addr.delete(); q_wd.delete(); q_we.delete();
`ifdef RISCV_MC_PERF_EN
        q_cc.delete(); q_ir.delete();
`endif
        stable_err = 0;
        wait_cycles = 0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        hold_reset();
        mem[64] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", mem_req); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %b exp 0", halted); end
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL rst_pc got %h exp 00000100", pc); end
        release_reset();
        #1;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL first_req got %b exp 1", mem_req); end
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL first_addr got %h exp 00000100", mem_addr); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL first_we got %b exp 0", mem_we); end
    endtask

    task automatic test_alu();
        hold_reset();
        mem[64] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        mem[65] = enc_i(6'h08, 5'd0, 5'd2, 16'd7);
        mem[66] = enc_r(5'd3, 5'd1, 5'd2, 6'h20);
        mem[67] = enc_i(6'h2B, 5'd0, 5'd3, 16'h0040);
        mem[68] = enc_j(32'h110);
        release_reset();
        run(30);
        checks++; if (q_addr[4] !== 32'h40 || q_we[4] !== 1'b1) begin errors++; $display("FAIL sw_addr got %h we %b exp 00000040 we 1", q_addr[4], q_we[4]); end
        checks++; if (q_wd[4] !== 32'd12) begin errors++; $display("FAIL sw_data got %0d exp 12", q_wd[4]); end
        checks++; if (q_cyc[1] - q_cyc[0] !== 4) begin errors++; $display("FAIL addi_cycles got %0d exp 4", q_cyc[1] - q_cyc[0]); end
        checks++; if (q_cyc[3] - q_cyc[2] !== 4) begin errors++; $display("FAIL rtype_cycles got %0d exp 4", q_cyc[3] - q_cyc[2]); end
        checks++; if (q_cyc[5] - q_cyc[3] !== 4) begin errors++; $display("FAIL sw_cycles got %0d exp 4", q_cyc[5] - q_cyc[3]); end
        checks++; if (q_addr[6] !== 32'h110 || q_cyc[6] - q_cyc[5] !== 3) begin errors++; $display("FAIL jump got %h/%0d exp 00000110/3", q_addr[6], q_cyc[6] - q_cyc[5]); end
`ifdef RISCV_MC_PERF_EN
        checks++; if (q_ir[5] !== 32'd4) begin errors++; $display("FAIL instret got %0d exp 4", q_ir[5]); end
        checks++; if (q_cc[5] !== 32'd16) begin errors++; $display("FAIL cycle_cnt got %0d exp 16", q_cc[5]); end
`endif
    endtask

    task automatic test_alu_ops();
        logic [31:0] exp_v [6];
        exp_v = '{32'hFFFF_FFF8, 32'd5, 32'hFFFF_FFFD, 32'd1, 32'd0, 32'd0};
        hold_reset();
        mem[64] = enc_i(6'h08, 5'd0, 5'd1, 16'hFFFD);
        mem[65] = enc_i(6'h08, 5'd0, 5'd2, 16'd5);
        mem[66] = enc_r(5'd3, 5'd1, 5'd2, 6'h22);
        mem[67] = enc_r(5'd4, 5'd1, 5'd2, 6'h24);
        mem[68] = enc_r(5'd5, 5'd1, 5'd2, 6'h25);
        mem[69] = enc_r(5'd6, 5'd1, 5'd2, 6'h2A);
        mem[70] = enc_r(5'd7, 5'd2, 5'd1, 6'h2A);
        mem[71] = enc_i(6'h08, 5'd0, 5'd0, 16'd9);
        mem[72] = enc_i(6'h2B, 5'd0, 5'd3, 16'h40);
        mem[73] = enc_i(6'h2B, 5'd0, 5'd4, 16'h44);
        mem[74] = enc_i(6'h2B, 5'd0, 5'd5, 16'h48);
        mem[75] = enc_i(6'h2B, 5'd0, 5'd6, 16'h4C);
        mem[76] = enc_i(6'h2B, 5'd0, 5'd7, 16'h50);
        mem[77] = enc_i(6'h2B, 5'd0, 5'd0, 16'h54);
        mem[78] = enc_j(32'h138);
        for (int i = 16; i < 22; i++) mem[i] = 32'hAAAA_AAAA;
        release_reset();
        run(80);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (mem[16+i] !== exp_v[i]) begin
                errors++;
                $display("FAIL alu_op%0d got %h exp %h", i, mem[16+i], exp_v[i]);
            end
        end
    endtask

    task automatic test_lw_wait();
        hold_reset();
        mem[32] = 32'hDEAD_BEEF;
        mem[64] = enc_i(6'h23, 5'd0, 5'd4, 16'h80);
        mem[65] = enc_i(6'h2B, 5'd0, 5'd4, 16'h44);
        mem[66] = enc_j(32'h108);
        data_wait = 3;
        release_reset();
        run(30);
        checks++; if (q_addr[1] !== 32'h80 || q_we[1] !== 1'b0) begin errors++; $display("FAIL lw_addr got %h we %b exp 00000080 we 0", q_addr[1], q_we[1]); end
        checks++; if (q_cyc[1] - q_cyc[0] !== 6) begin errors++; $display("FAIL lw_rd_cycle got %0d exp 6", q_cyc[1] - q_cyc[0]); end
        checks++; if (q_addr[2] !== 32'h104 || q_cyc[2] - q_cyc[0] !== 8) begin errors++; $display("FAIL lw_cycles got %h/%0d exp 00000104/8", q_addr[2], q_cyc[2] - q_cyc[0]); end
        checks++; if (q_wd[3] !== 32'hDEAD_BEEF || q_addr[3] !== 32'h44) begin errors++; $display("FAIL lw_data got %h@%h exp deadbeef@00000044", q_wd[3], q_addr[3]); end
        checks++; if (wait_cycles !== 6) begin errors++; $display("FAIL wait_cycles got %0d exp 6", wait_cycles); end
        checks++; if (stable_err !== 0) begin errors++; $display("FAIL wait_stable got %0d exp 0", stable_err); end
    endtask

    task automatic test_beq();
        hold_reset();
        mem[64] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
        mem[65] = enc_i(6'h08, 5'd0, 5'd2, 16'd2);
        mem[66] = enc_i(6'h04, 5'd1, 5'd2, 16'd5);
        mem[67] = enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF);
        release_reset();
        run(25);
        checks++; if (q_addr[3] !== 32'h10C || q_cyc[3] - q_cyc[2] !== 3) begin errors++; $display("FAIL beq_nt got %h/%0d exp 0000010c/3", q_addr[3], q_cyc[3] - q_cyc[2]); end
        checks++; if (q_addr[4] !== 32'h10C || q_cyc[4] - q_cyc[3] !== 3) begin errors++; $display("FAIL beq_t got %h/%0d exp 0000010c/3", q_addr[4], q_cyc[4] - q_cyc[3]); end
        checks++; if (q_addr[5] !== 32'h10C) begin errors++; $display("FAIL beq_loop got %h exp 0000010c", q_addr[5]); end
    endtask

    task automatic test_halt();
        hold_reset();
        mem[64] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
        mem[65] = 32'hFC00_0000;
        release_reset();
        run(12);
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag got %b exp 1", halted); end
        run(10);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL halt_req got %b exp 0", mem_req); end
        checks++; if (q_cyc.size() !== 2) begin errors++; $display("FAIL halt_accesses got %0d exp 2", q_cyc.size()); end
        checks++; if (pc !== 32'h108) begin errors++; $display("FAIL halt_pc got %h exp 00000108", pc); end
        hold_reset();
        mem[64] = enc_r(5'd1, 5'd0, 5'd0, 6'h3F);
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_clear got %b exp 0", halted); end
        release_reset();
        #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin errors++; $display("FAIL halt_refetch got %b@%h exp 1@00000100", mem_req, mem_addr); end
        run(8);
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL bad_funct got %b exp 1", halted); end
    endtask

    task automatic test_reset_mid();
        hold_reset();
        mem[64] = enc_i(6'h23, 5'd0, 5'd5, 16'h80);
        data_wait = 50;
        release_reset();
        run(6);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mid_req got %b exp 0", mem_req); end
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL mid_pc got %h exp 00000100", pc); end
        checks++; if (q_cyc.size() !== 1) begin errors++; $display("FAIL mid_accesses got %0d exp 1", q_cyc.size()); end
        data_wait = 0;
        release_reset();
        run(2);
        checks++; if (q_addr[q_addr.size()-1] !== 32'h100) begin errors++; $display("FAIL mid_refetch got %h exp 00000100", q_addr[q_addr.size()-1]); end
    endtask

    initial begin
        reset = 1'b1;
        data_wait = 0;
        test_reset();
        test_alu();
        test_alu_ops();
        test_lw_wait();
        test_beq();
        test_halt();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
